// File: rtl/mybusmatrix5x7_arb_rr.sv
// Round-robin slave-port arbiter for the 5x7 AHB bus matrix; grant is frozen
// across fixed bursts, locked sequences and undefined INCR bursts up to a beat limit.
//   state | meaning
//   NONE  | {no_port,arb_hold}=10, no input port selected
//   OWNED | {no_port,arb_hold}=00, port selected, open to arbitration
//   HELD  | {no_port,arb_hold}=01, grant frozen by burst, lock or INCR hold
module mybusmatrix5x7_arb_rr #(
  parameter int NUM_PORTS      = 5,
  parameter int INCR_MAX_BEATS = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [2:0]           addr_in_port,
  output logic                 no_port,
  output logic                 arb_hold
);

  typedef enum logic [1:0] {
    ST_OWNED = 2'b00,
    ST_HELD  = 2'b01,
    ST_NONE  = 2'b10
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [4:0] INCR_LIMIT = 5'(INCR_MAX_BEATS);

  state_t     state;
  logic [2:0] addr_q;
  logic [2:0] last_grant;
  logic [4:0] beat_cnt;
  logic [4:0] incr_cnt;
  logic       incr_act;

  logic [4:0] rem;
  logic [4:0] incr_cnt_next;
  logic       incr_act_next;
  logic       hold_next;
  logic [7:0] req_ext;
  logic [3:0] scan_idx;
  logic [2:0] grant_pick;
  logic       req_found;

  assign req_ext = 8'(req_port);

  always_comb begin
    rem           = '0;
    incr_act_next = incr_act;
    incr_cnt_next = incr_cnt;
    if (!HSELM) begin
      incr_act_next = 1'b0;
    end else begin
      case (HTRANSM)
        TR_NONSEQ: begin
          case (HBURSTM[2:1])
            2'b01:   rem = 5'd3;
            2'b10:   rem = 5'd7;
            2'b11:   rem = 5'd15;
            default: rem = 5'd0;
          endcase
          if (HBURSTM == 3'b001) begin
            incr_act_next = 1'b1;
            incr_cnt_next = 5'd1;
          end else begin
            incr_act_next = 1'b0;
          end
        end
        TR_SEQ: begin
          if (beat_cnt != 5'd0) rem = beat_cnt - 5'd1;
          if (incr_act && incr_cnt != 5'd31) incr_cnt_next = incr_cnt + 5'd1;
        end
        TR_BUSY: rem = beat_cnt;
        default: incr_act_next = 1'b0;
      endcase
    end
    hold_next = HMASTLOCKM | (rem != 5'd0) | (incr_act_next & (incr_cnt_next < INCR_LIMIT));
  end

  // Circular scan starting one past the last winner
  always_comb begin
    req_found  = 1'b0;
    grant_pick = last_grant;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = {1'b0, last_grant} + 4'(k);
      if (scan_idx >= 4'(NUM_PORTS)) scan_idx = scan_idx - 4'(NUM_PORTS);
      if (!req_found && req_ext[scan_idx[2:0]]) begin
        req_found  = 1'b1;
        grant_pick = scan_idx[2:0];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_NONE;
      addr_q     <= '0;
      last_grant <= 3'(NUM_PORTS - 1);
      beat_cnt   <= '0;
      incr_cnt   <= '0;
      incr_act   <= 1'b0;
    end else if (HREADYM) begin
      beat_cnt <= rem;
      incr_cnt <= incr_cnt_next;
      incr_act <= incr_act_next;
      if (hold_next) begin
        state <= ST_HELD;
      end else if (req_found) begin
        addr_q     <= grant_pick;
        last_grant <= grant_pick;
        state      <= ST_OWNED;
      end else if (HSELM) begin
        state <= ST_OWNED;
      end else begin
        state <= ST_NONE;
      end
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = state[1];
  assign arb_hold     = state[0];

endmodule

// File: doc/mybusmatrix5x7_arb_rr.md
# mybusmatrix5x7_arb_rr

Round-robin output-stage arbiter for one slave port of the 5x7 AHB bus matrix. It chooses which of the five input stages drives the shared slave's address phase. Unlike the fixed-priority arbiters, it rotates grant fairly between requesters. Grant is held for the whole of a fixed-length burst, for locked sequences, and for undefined-length INCR bursts up to a beat limit. It sits between the input-stage request lines and the output-stage address mux, and produces the same `addr_in_port`/`no_port` pair.

## Interface
- `NUM_PORTS`, 5 — number of input ports; legal range 2..5.
- `INCR_MAX_BEATS`, 16 — maximum number of beats an undefined-length INCR burst holds the grant; legal range 1..31.

- `HCLK`  in  1  AHB system clock.
- `HRESETn`  in  1  reset; one clock, asynchronous assert, active-low.
- `req_port`  in  NUM_PORTS  per-port request; bit i is input port i.
- `HREADYM`  in  1  transfer done from the slave; all state updates are qualified by it.
- `HSELM`  in  1  slave select of the current address phase.
- `HTRANSM`  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HBURSTM`  in  3  burst type of the current address phase.
- `HMASTLOCKM`  in  1  locked transfer.
- `addr_in_port`  out  3  selected input port (registered).
- `no_port`  out  1  1 = no input port selected (registered).
- `arb_hold`  out  1  1 = grant is frozen by a burst, a lock or an INCR hold (registered).

## Operation
- Registers and their reset values:
  - `addr_in_port` = 0, `no_port` = 1, `arb_hold` = 0.
  - `last_grant` = NUM_PORTS-1, so port 0 wins first.
  - `beat_cnt[4:0]` = 0, `incr_cnt[4:0]` = 0, `incr_act` = 0.
- All registers update only on a rising `HCLK` with `HREADYM`=1; otherwise they hold.
- Remaining-beat computation `rem`, evaluated only when `HSELM`=1 (when `HSELM`=0, `rem`=0 and `incr_act` is cleared):
  - NONSEQ with HBURSTM = 010/011: `rem`=3.
  - NONSEQ with HBURSTM = 100/101: `rem`=7.
  - NONSEQ with HBURSTM = 110/111: `rem`=15.
  - NONSEQ with SINGLE or INCR: `rem`=0.
  - SEQ with `beat_cnt`>0: `rem`=`beat_cnt`-1.
  - BUSY: `rem`=`beat_cnt`.
  - IDLE: `rem`=0. An early-terminated burst releases the grant.
- INCR tracking:
  - NONSEQ with INCR: `incr_act`=1, `incr_cnt`=1.
  - SEQ with `incr_act`=1: `incr_cnt`+1, saturating at 31.
  - IDLE, or NONSEQ of any non-INCR type: `incr_act`=0.
- `beat_cnt` <= `rem` at every qualified edge.
- Hold condition: `hold_next` = `HMASTLOCKM` | (`rem`≠0) | (`incr_act_next` & `incr_cnt_next` < `INCR_MAX_BEATS`).
- State machine, with state encoded by {`no_port`, `arb_hold`}:
  - NONE (1,0): no port selected.
  - OWNED (0,0): port selected and arbitrable.
  - HELD (0,1): grant frozen.
- Next-port selection, evaluated in priority order:
  1. `hold_next`=1: keep `addr_in_port`; go to HELD.
  2. Any `req_port` bit set: grant the first requesting port scanning circularly from `last_grant`+1, wrapping at NUM_PORTS-1 to 0. Set `last_grant` to that port; go to OWNED.
  3. No requests and `HSELM`=1: keep the current port; go to OWNED.
  4. Otherwise: go to NONE. `addr_in_port` keeps its value.
- `last_grant` changes only in case 2. A port that is re-granted while it is the only requester still updates `last_grant`.
- Request bits at indices ≥ NUM_PORTS are ignored.
- Simultaneous events:
  - Lock takes precedence over burst completion.
  - When a burst's last beat coincides with new requests, arbitration happens at that same edge, so there is no dead cycle.
- A reset mid-burst returns all registers to their reset values immediately (asynchronous).

## Timing
- The decision is combinational from the inputs and registered on the qualified edge. `addr_in_port` is valid one cycle after the deciding `HREADYM`=1 edge.
- While `HREADYM`=0, the outputs are stable for the whole wait-state period.
- A fixed burst of length L holds the grant for exactly L address phases. The grant may change at the edge that completes the L-th address phase.
- An INCR burst holds the grant for at most `INCR_MAX_BEATS` address phases. It is arbitrable at the edge that accepts the beat with `incr_cnt`=`INCR_MAX_BEATS`.

## Test plan
- Reset, with all requests low and `HSELM`=0: `no_port`=1, `addr_in_port`=0, `arb_hold`=0. These values hold after release of reset.
- `req_port`=5'b11111 held high, SINGLE NONSEQ transfers, `HREADYM`=1 every cycle: grant sequence 0,1,2,3,4,0,1.
- Port 1 issues INCR8 NONSEQ then 7 SEQ while port 0 requests throughout: `addr_in_port`=1 for 8 address phases with `arb_hold`=1. On the 8th accept edge the grant goes to port 0.
- Port 2 issues INCR4 with `HREADYM`=0 for 3 cycles mid-burst, then BUSY, then IDLE after beat 2: outputs are frozen during the wait states. The grant is released at the IDLE edge to the next requester.
- Port 3 issues an undefined INCR with `INCR_MAX_BEATS`=16 and continuous SEQ while port 4 requests: port 4 is granted at the 16th accept edge. With `HMASTLOCKM`=1 throughout the same run, port 3 keeps the grant.
- Reset asserted during beat 5 of an INCR16: `no_port`=1 and `arb_hold`=0 asynchronously. After release, the next grant goes to port 0.
